// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_e;

   // Requester-id width; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled as one interface.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            req_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            rvalid;
   logic [DATA_WIDTH-1:0]         rdata;
   logic [NUM_REQ-1:0]            rerr;
   logic                          busy;

   logic                          mem_en;
   logic [ADDR_WIDTH-1:0]         mem_address;
   logic [DATA_WIDTH-1:0]         mem_data_in;
   logic [DATA_WIDTH-1:0]         mem_data_out;
   logic                          mem_valid_out;

   modport slave (
      input  req, req_we, req_addr, req_wdata, mem_data_out, mem_valid_out,
      output gnt, rvalid, rdata, rerr, busy, mem_en, mem_address, mem_data_in
   );

   modport master (
      output req, req_we, req_addr, req_wdata, mem_data_out, mem_valid_out,
      input  gnt, rvalid, rdata, rerr, busy, mem_en, mem_address, mem_data_in
   );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts one past the last grant.
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDW     = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     last_grant_i,
   output logic [IDW-1:0]     winner_o,
   output logic               valid_o
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!valid_o && req_i[(int'(last_grant_i) + i) % NUM_REQ]) begin
            winner_o = IDW'((int'(last_grant_i) + i) % NUM_REQ);
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters,
// one transaction in flight at a time (IDLE -> ISSUE [-> RESP] -> IDLE).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   localparam int IDW = id_width(NUM_REQ);

   state_e                  state_q;
   logic [IDW-1:0]          id_q;
   logic [IDW-1:0]          last_grant_q;
   logic [NUM_REQ-1:0]      gnt_q;
   logic [NUM_REQ-1:0]      rvalid_q;
   logic [NUM_REQ-1:0]      rerr_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    busy_q;
   logic                    mem_en_q;
   logic [ADDR_WIDTH-1:0]   mem_address_q;
   logic [DATA_WIDTH-1:0]   mem_data_in_q;
   logic [IDW-1:0]          win_id;
   logic                    win_valid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr (
      .req_i        (bus.req),
      .last_grant_i (last_grant_q),
      .winner_o     (win_id),
      .valid_o      (win_valid)
   );

   // NOTE: all state uses non-blocking assignments; pulse outputs are cleared
   // by default each cycle and set only where the FSM raises them.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         id_q          <= '0;
         last_grant_q  <= IDW'(NUM_REQ - 1);
         gnt_q         <= '0;
         rvalid_q      <= '0;
         rerr_q        <= '0;
         rdata_q       <= '0;
         busy_q        <= 1'b0;
         mem_en_q      <= 1'b0;
         mem_address_q <= '0;
         mem_data_in_q <= '0;
      end else begin
         gnt_q    <= '0;
         rvalid_q <= '0;
         rerr_q   <= '0;
         mem_en_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (win_valid) begin
                  id_q           <= win_id;
                  last_grant_q   <= win_id;
                  gnt_q[win_id]  <= 1'b1;
                  mem_en_q       <= bus.req_we[win_id];
                  mem_address_q  <= bus.req_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
                  mem_data_in_q  <= bus.req_wdata[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
                  busy_q         <= 1'b1;
                  state_q        <= ISSUE;
               end
            end
            ISSUE: begin
               // mem_en_q is high here exactly when the latched operation is a write.
               if (mem_en_q) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  state_q <= RESP;
               end
            end
            RESP: begin
               if (bus.mem_valid_out) begin
                  rvalid_q[id_q] <= 1'b1;
                  rdata_q        <= bus.mem_data_out;
               end else begin
                  rerr_q[id_q]   <= 1'b1;
               end
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.rvalid      = rvalid_q;
   assign bus.rerr        = rerr_q;
   assign bus.rdata       = rdata_q;
   assign bus.busy        = busy_q;
   assign bus.mem_en      = mem_en_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_data_in = mem_data_in_q;

endmodule
